fifo_uart_tx: RTL

Downstream drain stage for the synchronous FIFO. Pops one word at a time through the FIFO's read port (`rd_en` / registered `data_out` / `f_empty`) and serialises it onto a UART line as start, data LSB-first, optional parity, and stop. It owns all read-side flow control, so the FIFO is never read while a frame is in flight.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_cnt.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_pkg                                              |
// | Brief    : Shared state encoding and parity constants for the    |
// |            FIFO-fed UART transmitter.                            |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int c_CLKS_PER_BIT_DEFAULT = 16;

  localparam logic c_PARITY_EVEN = 1'b0;
  localparam logic c_PARITY_ODD  = 1'b1;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_FETCH  = 3'd1;
  localparam logic [2:0] c_ST_LOAD   = 3'd2;
  localparam logic [2:0] c_ST_START  = 3'd3;
  localparam logic [2:0] c_ST_DATA   = 3'd4;
  localparam logic [2:0] c_ST_PARITY = 3'd5;
  localparam logic [2:0] c_ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = c_ST_IDLE,
    ST_FETCH  = c_ST_FETCH,
    ST_LOAD   = c_ST_LOAD,
    ST_START  = c_ST_START,
    ST_DATA   = c_ST_DATA,
    ST_PARITY = c_ST_PARITY,
    ST_STOP   = c_ST_STOP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_baud_cnt                                         |
// | Brief    : Per-bit cycle counter; tick marks the last cycle of a |
// |            bit, pre_tick the cycle before it.                    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_PRE   = c_CNT_W'(CLKS_PER_BIT - 2);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign tick     = (r_cnt == c_LAST);
  // Lets the owner register a last-cycle strobe one cycle ahead.
  assign pre_tick = (r_cnt == c_PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                          |
// | Brief    : Pops words from a synchronous FIFO and serialises     |
// |            them as UART frames (start, LSB-first, parity, stop). |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_empty,
  input  logic [DATAWIDTH-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int                 c_BIT_W    = $clog2(DATAWIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATAWIDTH - 1);
  localparam logic               c_PAR_SEL  = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;

  state_t               r_state,   w_state_n;
  logic [DATAWIDTH-1:0] r_shift,   w_shift_n;
  logic [c_BIT_W-1:0]   r_bit_cnt, w_bit_cnt_n;
  logic                 r_parity,  w_parity_n;
  logic                 w_tx_n;
  logic                 w_clr;
  logic                 w_tick;
  logic                 w_pre_tick;
  logic                 r_tx;
  logic                 r_rd_en;
  logic                 r_busy;
  logic                 r_tx_done;

  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bit_cnt_n = r_bit_cnt;
    w_parity_n  = r_parity;
    w_tx_n      = 1'b1;

    case (r_state)
      ST_IDLE:   if (!f_empty) w_state_n = ST_FETCH;
      ST_FETCH:  w_state_n = ST_LOAD;
      ST_LOAD: begin
        w_shift_n   = fifo_data;
        w_parity_n  = (^fifo_data) ^ c_PAR_SEL;
        w_bit_cnt_n = '0;
        w_state_n   = ST_START;
      end
      ST_START:  if (w_tick) w_state_n = ST_DATA;
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == c_LAST_BIT) begin
            w_state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_n = r_bit_cnt + c_BIT_W'(1);
            w_shift_n   = r_shift >> 1;
          end
        end
      end
      ST_PARITY: if (w_tick) w_state_n = ST_STOP;
      ST_STOP:   if (w_tick) w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx is a clean flop.
    case (w_state_n)
      ST_START:  w_tx_n = 1'b0;
      ST_DATA:   w_tx_n = w_shift_n[0];
      ST_PARITY: w_tx_n = w_parity_n;
      default:   w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_parity  <= w_parity_n;
      r_tx      <= w_tx_n;
      r_rd_en   <= (w_state_n == ST_FETCH);
      r_busy    <= (w_state_n != ST_IDLE);
      r_tx_done <= (r_state == ST_STOP) && w_pre_tick;
    end
  end

  assign tx         = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;

endmodule
`default_nettype wire
